time_set_sequencer: RTL and testbench



---
 rtl/time_set_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_time_set_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/time_set_sequencer.sv
// time_set_sequencer: converts debounced set buttons into single-cycle counter commands
// while the timer is in its edit state. One button owns the counter at a time; a held
// owner auto-repeats after HOLD_CYCLES, then every SLOW_CYCLES.
// Optional macro ACCEL_EN: after FAST_AFTER repeat pulses the spacing drops to FAST_CYCLES
// and fast_mode is raised. Without it, REPEAT stays at SLOW_CYCLES and fast_mode is 0.
module time_set_sequencer #(
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned SLOW_CYCLES = 12500000,
  parameter int unsigned FAST_CYCLES = 2500000,
  parameter int unsigned FAST_AFTER  = 8
) (
  input  logic CLK_50MHZ,
  input  logic reset,
  input  logic edit_en,
  input  logic sec_req,
  input  logic min_req,
  input  logic clr_req,
  output logic inc_seg,
  output logic inc_min,
  output logic clr_timer,
  output logic busy,
  output logic fast_mode
);

  localparam int unsigned MaxHs     = (HOLD_CYCLES > SLOW_CYCLES) ? HOLD_CYCLES : SLOW_CYCLES;
  localparam int unsigned MaxCycles = (MaxHs > FAST_CYCLES) ? MaxHs : FAST_CYCLES;
  localparam int unsigned TW        = $clog2(MaxCycles) + 1;

  // The timer is cleared on each pulse, so a pulse is due when it reaches CYCLES-1.
  localparam logic [TW-1:0] HoldLast = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] SlowLast = TW'(SLOW_CYCLES - 1);

  // Zero-length periods would make the timer compare unreachable.
  localparam bit CfgOk = (HOLD_CYCLES > 0) && (SLOW_CYCLES > 0) && (FAST_CYCLES > 0) &&
                         (FAST_AFTER > 0);
  if (!CfgOk) begin : g_cfg_err
    $error("time_set_sequencer: cycle parameters and FAST_AFTER must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;
  typedef enum logic {OwnSec, OwnMin} owner_e;

  // Bit order for the request vectors: [2] clear, [1] minutes, [0] seconds.
  logic [2:0] req_now;
  logic [2:0] req_prev_q;
  logic [2:0] edge_q;
  logic       armed_q;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] period_last;
  logic          owner_level;

  logic inc_seg_q, inc_seg_d;
  logic inc_min_q, inc_min_d;
  logic clr_q, clr_d;
  logic busy_q;

`ifdef ACCEL_EN
  localparam int unsigned   RW         = $clog2(FAST_AFTER + 1);
  localparam logic [RW-1:0] FastAfterV = RW'(FAST_AFTER);
  localparam logic [TW-1:0] FastLast   = TW'(FAST_CYCLES - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic [RW-1:0] rpt_next;
  logic          fast_q, fast_d;
`endif

  assign req_now = {clr_req, min_req, sec_req};

  // Press detection: registered rising edges. armed_q masks the first sample after reset
  // so a button still held through reset needs a fresh press.
  always_ff @(posedge CLK_50MHZ) begin
    if (reset) begin
      req_prev_q <= '0;
      edge_q     <= '0;
      armed_q    <= 1'b0;
    end else begin
      req_prev_q <= req_now;
      edge_q     <= armed_q ? (req_now & ~req_prev_q) : 3'b000;
      armed_q    <= 1'b1;
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge CLK_50MHZ) begin
    if (reset) begin
      state_q   <= StIdle;
      owner_q   <= OwnSec;
      timer_q   <= '0;
      inc_seg_q <= 1'b0;
      inc_min_q <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ACCEL_EN
      rpt_q     <= '0;
      fast_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      inc_seg_q <= inc_seg_d;
      inc_min_q <= inc_min_d;
      clr_q     <= clr_d;
      // busy follows the registered state, so it drops the cycle after IDLE is entered.
      busy_q    <= (state_q != StIdle);
`ifdef ACCEL_EN
      rpt_q     <= rpt_d;
      fast_q    <= fast_d;
`endif
    end
  end

  // Next-state logic: button arbitration, hold/repeat timing, release and abort.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    inc_seg_d = 1'b0;
    inc_min_d = 1'b0;
    clr_d     = 1'b0;
`ifdef ACCEL_EN
    rpt_d     = rpt_q;
    fast_d    = fast_q;
    rpt_next  = (rpt_q < FastAfterV) ? rpt_q + 1'b1 : rpt_q;
    period_last = (state_q == StHold) ? HoldLast : (fast_q ? FastLast : SlowLast);
`else
    period_last = (state_q == StHold) ? HoldLast : SlowLast;
`endif
    owner_level = (owner_q == OwnMin) ? min_req : sec_req;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
`ifdef ACCEL_EN
        rpt_d   = '0;
        fast_d  = 1'b0;
`endif
        if (edit_en) begin
          if (edge_q[2]) begin
            clr_d = 1'b1;
          end else if (edge_q[1]) begin
            // Minutes outranks seconds; a simultaneous seconds edge is dropped.
            inc_min_d = 1'b1;
            owner_d   = OwnMin;
            state_d   = StHold;
          end else if (edge_q[0]) begin
            inc_seg_d = 1'b1;
            owner_d   = OwnSec;
            state_d   = StHold;
          end
        end
      end

      StHold, StRepeat: begin
        if (!edit_en || edge_q[2] || !owner_level) begin
          // Leaving edit, clear abort and release all win over a pulse that is due.
          clr_d   = edit_en && edge_q[2];
          state_d = StIdle;
          timer_d = '0;
`ifdef ACCEL_EN
          rpt_d   = '0;
          fast_d  = 1'b0;
`endif
        end else if (timer_q == period_last) begin
          inc_seg_d = (owner_q == OwnSec);
          inc_min_d = (owner_q == OwnMin);
          timer_d   = '0;
          state_d   = StRepeat;
`ifdef ACCEL_EN
          rpt_d  = (state_q == StHold) ? RW'(1) : rpt_next;
          fast_d = ((state_q == StHold) ? RW'(1) : rpt_next) >= FastAfterV;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  assign inc_seg   = inc_seg_q;
  assign inc_min   = inc_min_q;
  assign clr_timer = clr_q;
  assign busy      = busy_q;
`ifdef ACCEL_EN
  assign fast_mode = fast_q;
`else
  assign fast_mode = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_sequencer.sv
// Directed bench for time_set_sequencer with short periods (8/4/2, fast after 3).
// Cycle c means: inputs are sampled at rising edge c, and outputs are observed just after
// rising edge c. A press sampled at cycle 0 produces its first pulse in cycle 1.
module tb_time_set_sequencer;

  logic clk = 1'b0;
  logic reset, edit_en, sec_req, min_req, clr_req;
  logic inc_seg, inc_min, clr_timer, busy, fast_mode;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] seg_v, min_v, clr_v, busy_v, fast_v;
  logic [63:0] exp_v;

  always #5 clk = ~clk;

  time_set_sequencer #(
    .HOLD_CYCLES(8),
    .SLOW_CYCLES(4),
    .FAST_CYCLES(2),
    .FAST_AFTER (3)
  ) dut (
    .CLK_50MHZ(clk),
    .reset    (reset),
    .edit_en  (edit_en),
    .sec_req  (sec_req),
    .min_req  (min_req),
    .clr_req  (clr_req),
    .inc_seg  (inc_seg),
    .inc_min  (inc_min),
    .clr_timer(clr_timer),
    .busy     (busy),
    .fast_mode(fast_mode)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; edit_en = 1'b1; sec_req = 1'b0; min_req = 1'b0; clr_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  // Returns {edit_en, clr_req, min_req, sec_req} for scenario sc at cycle c.
  function automatic logic [3:0] stim(input int sc, input int c);
    logic e, cl, mi, se;
    e = 1'b1; cl = 1'b0; mi = 1'b0; se = 1'b0;
    case (sc)
      1: se = 1'b1;
      3: begin se = 1'b1; mi = 1'b1; end
      4: se = (c < 9);
      5: begin se = 1'b1; cl = (c == 5 || c == 6); end
      6: begin
        e  = 1'b0;
        se = (c >= 2 && c <= 4);
        mi = (c >= 6 && c <= 8);
        cl = (c >= 10 && c <= 12);
      end
      7: begin e = (c >= 4); mi = (c >= 1); end
      default: ;
    endcase
    return {e, cl, mi, se};
  endfunction

  task automatic run(input int sc, input int n);
    logic [3:0] s;
    seg_v = '0; min_v = '0; clr_v = '0; busy_v = '0; fast_v = '0;
    for (int c = 0; c < n; c++) begin
      s = stim(sc, c);
      {edit_en, clr_req, min_req, sec_req} = s;
      tick();
      seg_v[c]  = inc_seg;
      min_v[c]  = inc_min;
      clr_v[c]  = clr_timer;
      busy_v[c] = busy;
      fast_v[c] = fast_mode;
    end
    edit_en = 1'b1; sec_req = 1'b0; min_req = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1; edit_en = 1'b1; sec_req = 1'b0; min_req = 1'b0; clr_req = 1'b0;
    tick();
    tick();
    check_eq("rst_inc_seg", 64'(inc_seg), 64'd0);
    check_eq("rst_inc_min", 64'(inc_min), 64'd0);
    check_eq("rst_clr", 64'(clr_timer), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_fast", 64'(fast_mode), 64'd0);

    // Seconds held: initial, hold, slow then (with ACCEL_EN) fast repeats
    do_reset();
    run(1, 26);
    exp_v = '0;
    exp_v[1] = 1'b1; exp_v[9] = 1'b1; exp_v[13] = 1'b1; exp_v[17] = 1'b1;
`ifdef ACCEL_EN
    exp_v[19] = 1'b1; exp_v[21] = 1'b1; exp_v[23] = 1'b1; exp_v[25] = 1'b1;
`else
    exp_v[21] = 1'b1; exp_v[25] = 1'b1;
`endif
    check_eq("hold_seg_pulses", seg_v, exp_v);
    exp_v = '0;
`ifdef ACCEL_EN
    for (int c = 17; c < 26; c++) exp_v[c] = 1'b1;
`endif
    check_eq("hold_fast_mode", fast_v, exp_v);
    check_eq("hold_min_quiet", min_v, 64'd0);
    check_eq("hold_clr_quiet", clr_v, 64'd0);
    check_eq("hold_busy_mid", 64'(busy_v[5]), 64'd1);

    // Simultaneous sec+min rise: minutes owns, seconds never pulses
    do_reset();
    run(3, 20);
    exp_v = '0;
    exp_v[1] = 1'b1; exp_v[9] = 1'b1; exp_v[13] = 1'b1; exp_v[17] = 1'b1;
`ifdef ACCEL_EN
    exp_v[19] = 1'b1;
`endif
    check_eq("both_min_pulses", min_v, exp_v);
    check_eq("both_seg_quiet", seg_v, 64'd0);

    // Release sampled at cycle 9 beats the due hold pulse
    do_reset();
    run(4, 16);
    exp_v = '0;
    exp_v[1] = 1'b1;
    check_eq("rel_seg_pulses", seg_v, exp_v);
    check_eq("rel_busy_c9", 64'(busy_v[9]), 64'd1);
    check_eq("rel_busy_after", 64'(busy_v[15:10]), 64'd0);
    check_eq("rel_min_quiet", min_v, 64'd0);

    // Clear edge at cycle 5 aborts the hold
    do_reset();
    run(5, 16);
    exp_v = '0;
    exp_v[6] = 1'b1;
    check_eq("abort_clr", clr_v, exp_v);
    exp_v = '0;
    exp_v[1] = 1'b1;
    check_eq("abort_seg", seg_v, exp_v);
    check_eq("abort_busy_idle", 64'(busy_v[15:7]), 64'd0);

    // edit_en low: presses of every button are ignored
    do_reset();
    run(6, 20);
    check_eq("noedit_seg", seg_v, 64'd0);
    check_eq("noedit_min", min_v, 64'd0);
    check_eq("noedit_clr", clr_v, 64'd0);
    check_eq("noedit_busy", busy_v, 64'd0);

    // Button pressed while edit_en low, still held when edit_en rises: no action
    do_reset();
    run(7, 16);
    check_eq("reenable_min", min_v, 64'd0);
    check_eq("reenable_busy", busy_v, 64'd0);

    // Reset in REPEAT: outputs clear, the held button stays inert afterwards
    do_reset();
    sec_req = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check_eq("midrst_seg", 64'(inc_seg), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_clr", 64'(clr_timer), 64'd0);
    check_eq("midrst_fast", 64'(fast_mode), 64'd0);
    reset = 1'b0;
    seg_v = '0; busy_v = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      seg_v[c]  = inc_seg;
      busy_v[c] = busy;
    end
    check_eq("postrst_held_seg", seg_v, 64'd0);
    check_eq("postrst_held_busy", busy_v, 64'd0);

    // Fresh press after the release works normally again
    sec_req = 1'b0;
    tick();
    run(4, 4);
    exp_v = '0;
    exp_v[1] = 1'b1;
    check_eq("repress_seg", seg_v, exp_v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
